// File: rtl/sim_seq_pkg.sv
// Shared types and elaboration helpers for the simulation reset/finish sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sim_seq_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    // Reset outputs of the BSV wrapper follow the BSV reset polarity.
`ifdef BSV_POSITIVE_RESET
    localparam logic RST_OUT_ACTIVE_DFLT = 1'b1;
`else
    localparam logic RST_OUT_ACTIVE_DFLT = 1'b0;
`endif

    typedef enum logic [SEQ_STATE_W-1:0] {
        HOLD    = 3'd0,
        MAIN_UP = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        FINISH  = 3'd4,
        DONE    = 3'd5
    } seq_state_t;

    // True when an unsigned value is representable in 'width' bits.
    function automatic bit fits_width(longint unsigned value, int unsigned width);
        if (width >= 64) begin
            return 1'b1;
        end
        return value < (64'd1 << width);
    endfunction

endpackage

// File: rtl/sim_sat_counter.sv
// Up-counter that stops at TERM and flags it; clear has priority over enable.
// Latency: count and terminal flag update one cycle after enable/clear.
// Backpressure: none; holds at TERM until cleared.
//
// Ports: CLK, RST (async, active-high), en (count this cycle), clr (sync clear),
//        at_term (count register equals TERM).
module sim_sat_counter #(
    parameter int unsigned W    = 11,
    parameter int unsigned TERM = 1023
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic at_term
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] count;

    assign at_term = (count == TERM_V);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !at_term) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sim_reset_finish_sequencer.sv
// Staged reset release for main/derived domains, cycle counter, and drained finish strobe.
// Latency: finish_req at edge N (RUN, idle) -> quiesce_req after N, finish_strobe for cycle after N+1.
// Backpressure: finish waits in DRAIN for design_idle, bounded by DRAIN_TIMEOUT cycles.
//
// Ports: CLK, RST (async, active-high), finish_req (level), design_idle,
//        dut_rst_out / derived_rst_out (RST_OUT_ACTIVE while held), quiesce_req,
//        finish_strobe (1-cycle), drain_timeout (sticky), cycle_count, seq_state (debug).
module sim_reset_finish_sequencer
    import sim_seq_pkg::*;
#(
    parameter int unsigned COUNT_W          = 32,
    parameter int unsigned MAIN_RST_CYCLES  = 20,
    parameter int unsigned DERIV_RST_CYCLES = 20,
    parameter int unsigned DRAIN_TIMEOUT    = 1024,
    parameter int unsigned TIMEOUT_W        = 11,
    parameter logic        RST_OUT_ACTIVE   = RST_OUT_ACTIVE_DFLT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               finish_req,
    input  logic               design_idle,
    output logic               dut_rst_out,
    output logic               derived_rst_out,
    output logic               quiesce_req,
    output logic               finish_strobe,
    output logic               drain_timeout,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [2:0]         seq_state
);

    // Elaboration-time parameter sanity.
    if (!fits_width(longint'(DERIV_RST_CYCLES), COUNT_W)) begin : g_bad_count_w
        $error("COUNT_W too narrow for DERIV_RST_CYCLES");
    end
    if (!fits_width(longint'(DRAIN_TIMEOUT), TIMEOUT_W)) begin : g_bad_timeout_w
        $error("TIMEOUT_W too narrow for DRAIN_TIMEOUT");
    end
    if (DERIV_RST_CYCLES < MAIN_RST_CYCLES) begin : g_bad_order
        $error("DERIV_RST_CYCLES must be >= MAIN_RST_CYCLES");
    end
    if (MAIN_RST_CYCLES < 1 || DRAIN_TIMEOUT < 1) begin : g_bad_zero
        $error("MAIN_RST_CYCLES and DRAIN_TIMEOUT must be at least 1");
    end

    // Release compares are against the pre-edge count, so the output reads
    // released exactly when cycle_count shows the configured value.
    localparam logic [COUNT_W-1:0] MAIN_REL  = COUNT_W'(MAIN_RST_CYCLES - 1);
    localparam logic [COUNT_W-1:0] DERIV_REL = COUNT_W'(DERIV_RST_CYCLES - 1);
    localparam bit                 SAME_EDGE = (DERIV_RST_CYCLES == MAIN_RST_CYCLES);

    seq_state_t state;
    logic       finish_pend;
    logic       drain_at_term;

    assign seq_state = state;

    sim_sat_counter #(
        .W    (TIMEOUT_W),
        .TERM (DRAIN_TIMEOUT - 1)
    ) u_drain_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .en      (state == DRAIN),
        .clr     (state != DRAIN),
        .at_term (drain_at_term)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= HOLD;
            cycle_count     <= '0;
            dut_rst_out     <= RST_OUT_ACTIVE;
            derived_rst_out <= RST_OUT_ACTIVE;
            quiesce_req     <= 1'b0;
            finish_strobe   <= 1'b0;
            drain_timeout   <= 1'b0;
            finish_pend     <= 1'b0;
        end else begin
            cycle_count   <= cycle_count + COUNT_W'(1);
            finish_strobe <= 1'b0;
            case (state)
                HOLD: begin
                    // Finish requests during reset are remembered, never abort the sequence.
                    if (finish_req) begin
                        finish_pend <= 1'b1;
                    end
                    if (cycle_count == MAIN_REL) begin
                        dut_rst_out <= ~RST_OUT_ACTIVE;
                        if (SAME_EDGE) begin
                            derived_rst_out <= ~RST_OUT_ACTIVE;
                            state           <= RUN;
                        end else begin
                            state <= MAIN_UP;
                        end
                    end
                end
                MAIN_UP: begin
                    if (finish_req) begin
                        finish_pend <= 1'b1;
                    end
                    if (cycle_count == DERIV_REL) begin
                        derived_rst_out <= ~RST_OUT_ACTIVE;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    if (finish_req || finish_pend) begin
                        quiesce_req <= 1'b1;
                        finish_pend <= 1'b0;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Idle takes priority over a coincident timeout.
                    if (design_idle) begin
                        finish_strobe <= 1'b1;
                        state         <= FINISH;
                    end else if (drain_at_term) begin
                        finish_strobe <= 1'b1;
                        drain_timeout <= 1'b1;
                        state         <= FINISH;
                    end
                end
                FINISH: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule
